// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO drain controller.
// Pure declarations: no latency, no backpressure.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Cycles from the FIFO seeing rd fall to dout updating; the minimum legal settle.
    localparam int FIFO_RD_LATENCY = 3;

endpackage

// File: rtl/fifo_reader_buf.sv
// In-order holding buffer, 1 entry (2 with FIFO_READER_PREFETCH_EN); head word drives m_data.
// Latency: a push is visible at the head after one edge; push and pop may share an edge.
// Backpressure: caller must not push when full nor pop when empty; head holds until popped.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int dbits = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [dbits-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [dbits-1:0] head_dat_o
);

`ifdef FIFO_READER_PREFETCH_EN
    logic [dbits-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;

    // Pop shifts first, then push appends behind whatever remains.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        if (pop_i) begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
        end
        if (push_i) begin
            if (cnt_d == 2'd0) begin
                slot0_d = push_dat_i;
            end else begin
                slot1_d = push_dat_i;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign count_o    = cnt_q;
    assign head_dat_o = slot0_q;
`else
    logic [dbits-1:0] slot0_q, slot0_d;
    logic             vld_q, vld_d;

    always_comb begin
        slot0_d = push_i ? push_dat_i : slot0_q;
        vld_d   = push_i | (vld_q & ~pop_i);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            vld_q   <= vld_d;
        end
    end

    assign count_o    = {1'b0, vld_q};
    assign head_dat_o = slot0_q;
`endif

endmodule

// File: rtl/fifo_reader.sv
// Drains a pulse-triggered FIFO into a valid/ready stream; FIFO_READER_PREFETCH_EN adds a 2nd slot.
// Latency: m_valid rises settle+2 edges after IDLE sees !fifo_empty; one word per settle+2 cycles max.
// Backpressure: no read is issued unless a holding slot is free; m_data holds while stalled.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int dbits  = 8,
    parameter int settle = FIFO_RD_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [dbits-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [dbits-1:0] m_data
);

    localparam int CW = $clog2(settle + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic            push;
    logic            pop;
    logic            slot_free;
    logic [1:0]      count;

    assign pop = m_valid & m_ready;

    // A read in flight never coexists with IDLE, so only occupied slots matter here.
`ifdef FIFO_READER_PREFETCH_EN
    assign slot_free = (count <= 2'd1);
`else
    assign slot_free = (count == 2'd0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    state_d = PULSE;
                    rd_d    = 1'b1;
                end
            end
            PULSE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CW'(settle - 1)) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    assign fifo_rd = rd_q;
    assign m_valid = (count != 2'd0);

    fifo_reader_buf #(
        .dbits (dbits)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (fifo_dout),
        .pop_i      (pop),
        .count_o    (count),
        .head_dat_o (m_data)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader against a behavioural model of the pulse-triggered FIFO.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

`ifdef FIFO_READER_PREFETCH_EN
    localparam int EXP_SPACE     = 5;
    localparam int EXP_BP_PULSES = 2;
`else
    localparam int EXP_SPACE     = 6;
    localparam int EXP_BP_PULSES = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       m_ready = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic       m_valid;
    logic [7:0] m_data;

    always #5 clock = ~clock;

    fifo_reader #(.dbits(8), .settle(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    // FIFO model: rd registered twice, acts on the falling edge, dout registered.
    logic [7:0] mem [4];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       rd1 = 1'b0;
    logic       rd2 = 1'b0;
    logic [7:0] dout_q = 8'h00;

    assign fifo_empty = (wr_cnt == rd_cnt);
    assign fifo_dout  = dout_q;

    always @(posedge clock) begin
        rd1 <= fifo_rd;
        rd2 <= rd1;
        if (rd2 && !rd1) begin
            dout_q <= mem[rd_cnt % 4];
            rd_cnt <= rd_cnt + 1;
        end
    end

    int   cyc = 0;
    int   pulses = 0;
    logic rd_seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (fifo_rd && !rd_seen) pulses <= pulses + 1;
        rd_seen <= fifo_rd;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: expected words queued at write time, popped on each transfer.
    logic [7:0] exp_q[$];
    int         prev_acc = -1;
    bit         chk_space = 1'b0;

    always @(negedge clock) begin
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no transfer", m_data);
            end else begin
                check("data", int'(m_data), int'(exp_q.pop_front()));
                if (chk_space && prev_acc >= 0) check("spacing", cyc - prev_acc, EXP_SPACE);
                prev_acc = cyc;
            end
        end
    end

    a_rd_single: assert property (@(posedge clock) disable iff (reset) fifo_rd |=> !fifo_rd)
        else begin
            errors++;
            $display("FAIL rd_consecutive: fifo_rd high two cycles, expected one");
        end

    a_data_stable: assert property (@(posedge clock) disable iff (reset)
                                    (m_valid && !m_ready) |=> $stable(m_data))
        else begin
            errors++;
            $display("FAIL data_stable: m_data changed to 0x%0h while stalled", m_data);
        end

    task automatic fifo_write(input logic [7:0] d, input bit expect_it);
        mem[wr_cnt % 4] = d;
        wr_cnt = wr_cnt + 1;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d words outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rel;
        int n;

        #2;
        check("rst_fifo_rd", int'(fifo_rd), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_state", int'(dut.state_q), int'(IDLE));

        // Single read with latency measurement
        fifo_write(8'hA5, 1'b1);
        m_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        rel  = cyc;
        base = pulses;
        n = 0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (m_valid) break;
        end
        check("t1_latency", cyc - rel, 5);
        wait_drain("t1", 30);
        tick(20);
        check("t1_pulses", pulses - base, 1);
        check("t1_empty", int'(fifo_empty), 1);

        // Ordered drain of a full FIFO
        chk_space = 1'b1;
        prev_acc  = -1;
        base = pulses;
        fifo_write(8'h11, 1'b1);
        fifo_write(8'h22, 1'b1);
        fifo_write(8'h33, 1'b1);
        fifo_write(8'h44, 1'b1);
        wait_drain("t2", 100);
        tick(20);
        check("t2_pulses", pulses - base, 4);
        chk_space = 1'b0;

        // Backpressure
        m_ready = 1'b0;
        base = pulses;
        fifo_write(8'h11, 1'b1);
        fifo_write(8'h22, 1'b1);
        tick(20);
        check("t3_pulses", pulses - base, EXP_BP_PULSES);
        check("t3_valid", int'(m_valid), 1);
        check("t3_head", int'(m_data), 8'h11);
        m_ready = 1'b1;
        wait_drain("t3", 50);
        tick(10);
        check("t3_total_pulses", pulses - base, 2);

        // Empty start
        base = pulses;
        tick(10);
        check("t4_no_pulse", pulses - base, 0);
        fifo_write(8'h7E, 1'b1);
        wait_drain("t4", 50);
        tick(5);
        check("t4_pulses", pulses - base, 1);

        // Reset during WAIT cycle 2; the first word is lost inside the FIFO
        reset = 1'b1;
        fifo_write(8'h11, 1'b0);
        fifo_write(8'h22, 1'b1);
        fifo_write(8'h33, 1'b1);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("t5_in_wait", int'(dut.state_q), int'(WAIT));
        check("t5_wait_cnt", int'(dut.cnt_q), 1);
        reset = 1'b1;
        #1;
        check("t5_rst_fifo_rd", int'(fifo_rd), 0);
        check("t5_rst_m_valid", int'(m_valid), 0);
        check("t5_rst_m_data", int'(m_data), 0);
        check("t5_rst_state", int'(dut.state_q), int'(IDLE));
        tick(3);
        reset = 1'b0;
        wait_drain("t5", 60);
        tick(10);
        check("t5_fifo_drained", rd_cnt, wr_cnt);
        check("t5_empty", int'(fifo_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
